// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the decode-stage instruction fields and the control word that the
//   main decoder produces for the datapath.
//
//   Handshake: there is no valid/ready pair. The decoder is a continuous
//   combinational map, so every input change is reflected in the outputs in
//   the same cycle. The only sequential effect is the reset bubble flag.
//
//   Signals
//     op_code             instruction [31:26]                (master -> slave)
//     control_unit_funct  instruction [5:0]                  (master -> slave)
//     eq_ne               1 = compared registers equal       (master -> slave)
//     pc_source           00 PC+4, 01 branch, 10 jump        (slave -> master)
//     out_select          00 ALU, 01 LUI, 10 mult, 11 HI/LO  (slave -> master)
//     mem_write/mem_read  data memory enables                (slave -> master)
//     reg_write           register file write enable         (slave -> master)
//     output_branch       branch taken                       (slave -> master)
//     ALUSrc_A            1 = immediate operand              (slave -> master)
//     ALU_Func            ALU operation                      (slave -> master)
//     se_ze               1 = sign-extend, 0 = zero-extend   (slave -> master)
//     reg_dst             1 = rd, 0 = rt                     (slave -> master)
//     start_mult          start multiplier                   (slave -> master)
//     mult_sign           1 = signed multiply                (slave -> master)
//     mem_to_reg          writeback select flag              (slave -> master)
//     in_rst              debug view of the reset bubble flag (slave -> master)
interface control_unit_if;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       eq_ne;

    logic [1:0] pc_source;
    logic [1:0] out_select;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       output_branch;
    logic       ALUSrc_A;
    logic [3:0] ALU_Func;
    logic       se_ze;
    logic       reg_dst;
    logic       start_mult;
    logic       mult_sign;
    logic       mem_to_reg;
    logic       in_rst;

    // Pipeline side: supplies the instruction fields, consumes controls.
    modport master (
        output op_code, control_unit_funct, eq_ne,
        input  pc_source, out_select, mem_write, mem_read, reg_write,
               output_branch, ALUSrc_A, ALU_Func, se_ze, reg_dst,
               start_mult, mult_sign, mem_to_reg, in_rst
    );

    // Decoder side.
    modport slave (
        input  op_code, control_unit_funct, eq_ne,
        output pc_source, out_select, mem_write, mem_read, reg_write,
               output_branch, ALUSrc_A, ALU_Func, se_ze, reg_dst,
               start_mult, mult_sign, mem_to_reg, in_rst
    );
endinterface

// File: rtl/control_unit_top.sv
// control_unit_top
//   Main instruction decoder of the pipelined MIPS-subset core (decode stage).
//   Maps opcode, R-type funct and the register-compare result to datapath,
//   ALU, multiplier, memory and PC-select controls with zero latency.
//   While the reset flag is set every output is forced to the bubble value
//   (all zero except mem_read).
//
//   Ports
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    control_unit_if.slave: instruction fields in, control word out
module control_unit_top (
    input  logic               clk,
    input  logic               rst_n,
    control_unit_if.slave      bus
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_XNOR  = 6'b001100;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    // ALU operations
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_XNOR = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1101;

    // Output mux selects
    localparam logic [1:0] OUT_ALU  = 2'b00;
    localparam logic [1:0] OUT_LUI  = 2'b01;
    localparam logic [1:0] OUT_MULT = 2'b10;
    localparam logic [1:0] OUT_HILO = 2'b11;

    // PC selects
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Reset bubble flag. Powers up set so the first cycles after
    // configuration issue bubbles even before rst_n is ever sampled low.
    logic in_rst = 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_rst <= 1'b1;
        end else begin
            in_rst <= 1'b0;
        end
    end

    logic [1:0] pc_source;
    logic [1:0] out_select;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       output_branch;
    logic       alu_src_a;
    logic [3:0] alu_func;
    logic       se_ze;
    logic       reg_dst;
    logic       start_mult;
    logic       mult_sign;
    logic       mem_to_reg;

    // Decode. Defaults are the bubble; each row only raises the fields it
    // needs, so anything unmatched (including the reset case) falls through
    // to the bubble.
    always_comb begin
        pc_source     = PC_PLUS4;
        out_select    = OUT_ALU;
        mem_write     = 1'b0;
        mem_read      = 1'b1;
        reg_write     = 1'b0;
        output_branch = 1'b0;
        alu_src_a     = 1'b0;
        alu_func      = ALU_AND;
        se_ze         = 1'b0;
        reg_dst       = 1'b0;
        start_mult    = 1'b0;
        mult_sign     = 1'b0;
        mem_to_reg    = 1'b0;

        if (!in_rst) begin
            case (bus.op_code)
                OP_RTYPE: begin
                    case (bus.control_unit_funct)
                        FN_ADD, FN_ADDU: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_ADD;
                        end
                        FN_SUB, FN_SUBU: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_SUB;
                        end
                        FN_AND: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_AND;
                        end
                        FN_OR: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_OR;
                        end
                        FN_XOR: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_XOR;
                        end
                        FN_XNOR: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_XNOR;
                        end
                        FN_SLT, FN_SLTU: begin
                            reg_write = 1'b1;
                            reg_dst   = 1'b1;
                            alu_func  = ALU_SLT;
                        end
                        FN_MFHI, FN_MFLO: begin
                            reg_write  = 1'b1;
                            reg_dst    = 1'b1;
                            out_select = OUT_HILO;
                        end
                        FN_MULT: begin
                            reg_write  = 1'b1;
                            reg_dst    = 1'b1;
                            out_select = OUT_MULT;
                            start_mult = 1'b1;
                            mult_sign  = 1'b1;
                        end
                        FN_MULTU: begin
                            reg_write  = 1'b1;
                            reg_dst    = 1'b1;
                            out_select = OUT_MULT;
                            start_mult = 1'b1;
                            mult_sign  = 1'b0;
                        end
                        default: ; // NOP and unknown funct: bubble
                    endcase
                end
                OP_J: begin
                    mem_to_reg = 1'b1;
                    pc_source  = PC_JUMP;
                end
                // Branch resolution uses only the current compare result.
                OP_BEQ: begin
                    mem_to_reg = 1'b1;
                    if (bus.eq_ne) begin
                        output_branch = 1'b1;
                        pc_source     = PC_BRANCH;
                    end
                end
                OP_BNE: begin
                    mem_to_reg = 1'b1;
                    if (!bus.eq_ne) begin
                        output_branch = 1'b1;
                        pc_source     = PC_BRANCH;
                    end
                end
                OP_ADDI, OP_ADDIU: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_ADD;
                    se_ze     = 1'b1;
                end
                OP_SLTI, OP_SLTIU: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_SLT;
                    se_ze     = 1'b1;
                end
                OP_ANDI: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_AND;
                end
                OP_ORI: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_OR;
                end
                OP_XORI: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_XOR;
                end
                OP_LUI: begin
                    reg_write  = 1'b1;
                    out_select = OUT_LUI;
                end
                OP_LW: begin
                    reg_write = 1'b1;
                    alu_src_a = 1'b1;
                    alu_func  = ALU_ADD;
                    se_ze     = 1'b1;
                end
                OP_SW: begin
                    alu_src_a = 1'b1;
                    alu_func  = ALU_ADD;
                    mem_write = 1'b1;
                    se_ze     = 1'b1;
                end
                default: ; // unknown opcode: bubble
            endcase
        end
    end

    assign bus.pc_source     = pc_source;
    assign bus.out_select    = out_select;
    assign bus.mem_write     = mem_write;
    assign bus.mem_read      = mem_read;
    assign bus.reg_write     = reg_write;
    assign bus.output_branch = output_branch;
    assign bus.ALUSrc_A      = alu_src_a;
    assign bus.ALU_Func      = alu_func;
    assign bus.se_ze         = se_ze;
    assign bus.reg_dst       = reg_dst;
    assign bus.start_mult    = start_mult;
    assign bus.mult_sign     = mult_sign;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.in_rst        = in_rst;

endmodule

// File: tb/tb_control_unit_top.sv
module tb_control_unit_top;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus();

    control_unit_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Expected control word packed as:
    // {pc_source, out_select, mw, mr, rw, br, srcA, alu[3:0], se, rd, sm, ms, m2r}
    typedef logic [17:0] ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        bit         use_funct;
        ctl_t       ctl;
    } row_t;

    row_t table_q[$];

    // Reset flag as the spec describes it: sampled from rst_n at each edge,
    // starts out set.
    bit m_in_rst = 1'b1;
    always @(posedge clk) m_in_rst <= !rst_n;

    function automatic ctl_t mk(bit rw, bit rd, bit src_a, logic [3:0] alu,
                                bit mw, bit m2r, bit se, logic [1:0] outs,
                                bit sm, bit ms, logic [1:0] pc, bit br);
        return {pc, outs, mw, 1'b1, rw, br, src_a, alu, se, rd, sm, ms, m2r};
    endfunction

    function automatic ctl_t bubble();
        return mk(0, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    endfunction

    task automatic add_r(input logic [5:0] fn, input ctl_t c);
        row_t r;
        r.op = 6'b000000; r.funct = fn; r.use_funct = 1'b1; r.ctl = c;
        table_q.push_back(r);
    endtask

    task automatic add_i(input logic [5:0] op, input ctl_t c);
        row_t r;
        r.op = op; r.funct = 6'b0; r.use_funct = 1'b0; r.ctl = c;
        table_q.push_back(r);
    endtask

    // Decode table transcribed row by row from the instruction list.
    task automatic build_table();
        ctl_t alu_r;
        add_r(6'b100000, mk(1,1,0,4'b0100,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100001, mk(1,1,0,4'b0100,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100010, mk(1,1,0,4'b1000,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100011, mk(1,1,0,4'b1000,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100100, mk(1,1,0,4'b0000,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100101, mk(1,1,0,4'b0001,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b100110, mk(1,1,0,4'b0010,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b001100, mk(1,1,0,4'b0011,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b101010, mk(1,1,0,4'b1101,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b101011, mk(1,1,0,4'b1101,0,0,0,2'b00,0,0,2'b00,0));
        add_r(6'b010000, mk(1,1,0,4'b0000,0,0,0,2'b11,0,0,2'b00,0));
        add_r(6'b010010, mk(1,1,0,4'b0000,0,0,0,2'b11,0,0,2'b00,0));
        add_r(6'b011000, mk(1,1,0,4'b0000,0,0,0,2'b10,1,1,2'b00,0));
        add_r(6'b011001, mk(1,1,0,4'b0000,0,0,0,2'b10,1,0,2'b00,0));
        alu_r = mk(1,0,1,4'b0100,0,0,1,2'b00,0,0,2'b00,0);
        add_i(6'b001000, alu_r);
        add_i(6'b001001, alu_r);
        add_i(6'b001010, mk(1,0,1,4'b1101,0,0,1,2'b00,0,0,2'b00,0));
        add_i(6'b001011, mk(1,0,1,4'b1101,0,0,1,2'b00,0,0,2'b00,0));
        add_i(6'b001100, mk(1,0,1,4'b0000,0,0,0,2'b00,0,0,2'b00,0));
        add_i(6'b001101, mk(1,0,1,4'b0001,0,0,0,2'b00,0,0,2'b00,0));
        add_i(6'b001110, mk(1,0,1,4'b0010,0,0,0,2'b00,0,0,2'b00,0));
        add_i(6'b001111, mk(1,0,0,4'b0000,0,0,0,2'b01,0,0,2'b00,0));
        add_i(6'b100011, mk(1,0,1,4'b0100,0,0,1,2'b00,0,0,2'b00,0));
        add_i(6'b101011, mk(0,0,1,4'b0100,1,0,1,2'b00,0,0,2'b00,0));
    endtask

    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input bit eq, input bit rst_flag);
        bit taken;
        if (rst_flag) return bubble();
        if (op == 6'b000010) return mk(0,0,0,4'b0000,0,1,0,2'b00,0,0,2'b10,0);
        if (op == 6'b000100 || op == 6'b000101) begin
            taken = (op == 6'b000100) ? eq : !eq;
            return mk(0,0,0,4'b0000,0,1,0,2'b00,0,0,
                      taken ? 2'b01 : 2'b00, taken);
        end
        foreach (table_q[i]) begin
            if (table_q[i].op == op &&
                (!table_q[i].use_funct || table_q[i].funct == fn))
                return table_q[i].ctl;
        end
        return bubble();
    endfunction

    function automatic ctl_t dut_ctl();
        return {bus.pc_source, bus.out_select, bus.mem_write, bus.mem_read,
                bus.reg_write, bus.output_branch, bus.ALUSrc_A, bus.ALU_Func,
                bus.se_ze, bus.reg_dst, bus.start_mult, bus.mult_sign,
                bus.mem_to_reg};
    endfunction

    // ---------------- driver ----------------
    // Change inputs just after the falling edge and leave time for the
    // combinational decode to settle before sampling, well clear of posedge.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input bit eq);
        @(negedge clk);
        bus.op_code            = op;
        bus.control_unit_funct = fn;
        bus.eq_ne              = eq;
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctl_t exp;
        // Power-up: flag starts set, before any edge.
        #1;
        exp = bubble();
        checks++;
        if (dut_ctl() !== exp) begin
            failures++;
            $display("FAIL powerup_bubble got=%b exp=%b", dut_ctl(), exp);
        end
        rst_n = 1'b0;
        drive(6'b001000, 6'b000000, 1'b0);
        drive(6'b001000, 6'b000000, 1'b0);
        drive(6'b001000, 6'b000000, 1'b0);
        checks++;
        if (dut_ctl() !== exp) begin
            failures++;
            $display("FAIL reset_bubble got=%b exp=%b", dut_ctl(), exp);
        end
        checks++;
        if (bus.in_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_flag got=%b exp=1", bus.in_rst);
        end
        // Release: flag still set until the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (dut_ctl() !== exp) begin
            failures++;
            $display("FAIL release_before_edge got=%b exp=%b", dut_ctl(), exp);
        end
        drive(6'b001000, 6'b000000, 1'b0);
        exp = mk(1,0,1,4'b0100,0,0,1,2'b00,0,0,2'b00,0);
        checks++;
        if (dut_ctl() !== exp) begin
            failures++;
            $display("FAIL addi_after_reset got=%b exp=%b", dut_ctl(), exp);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b001100, 6'b101010};
        logic [3:0] alus [7] = '{4'b0100, 4'b1000, 4'b0000, 4'b0001,
                                4'b0010, 4'b0011, 4'b1101};
        for (int i = 0; i < 7; i++) begin
            drive(6'b000000, fns[i], 1'($urandom_range(0, 1)));
            checks++;
            if (bus.ALU_Func !== alus[i] || bus.reg_write !== 1'b1 ||
                bus.reg_dst !== 1'b1 || dut_ctl() !== model(6'b0, fns[i], 1'b0, 1'b0)) begin
                failures++;
                $display("FAIL rtype_%b got=%b exp_alu=%b", fns[i], dut_ctl(), alus[i]);
            end
        end
    endtask

    task automatic test_mult();
        drive(6'b000000, 6'b011000, 1'b0);
        checks++;
        if (bus.out_select !== 2'b10 || bus.start_mult !== 1'b1 || bus.mult_sign !== 1'b1) begin
            failures++;
            $display("FAIL mult got=%b exp out=10 sm=1 ms=1", dut_ctl());
        end
        drive(6'b000000, 6'b011001, 1'b1);
        checks++;
        if (bus.out_select !== 2'b10 || bus.start_mult !== 1'b1 || bus.mult_sign !== 1'b0) begin
            failures++;
            $display("FAIL multu got=%b exp out=10 sm=1 ms=0", dut_ctl());
        end
        drive(6'b000000, 6'b010000, 1'b0);
        checks++;
        if (bus.out_select !== 2'b11 || bus.start_mult !== 1'b0 || bus.reg_write !== 1'b1) begin
            failures++;
            $display("FAIL mfhi got=%b exp out=11 sm=0 rw=1", dut_ctl());
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        bit         eqs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit         tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 6'($urandom_range(0, 63)), eqs[i]);
            checks++;
            if (bus.output_branch !== tk[i] || bus.pc_source !== (tk[i] ? 2'b01 : 2'b00) ||
                bus.mem_to_reg !== 1'b1) begin
                failures++;
                $display("FAIL branch_%0d got br=%b pc=%b m2r=%b exp br=%b", i,
                         bus.output_branch, bus.pc_source, bus.mem_to_reg, tk[i]);
            end
        end
        drive(6'b000010, 6'b000000, 1'b1);
        checks++;
        if (bus.pc_source !== 2'b10 || bus.output_branch !== 1'b0) begin
            failures++;
            $display("FAIL jump got pc=%b br=%b exp pc=10 br=0", bus.pc_source, bus.output_branch);
        end
    endtask

    task automatic test_imm_mem();
        drive(6'b001100, 6'b100000, 1'b0);
        checks++;
        if (bus.se_ze !== 1'b0 || bus.ALU_Func !== 4'b0000 || bus.ALUSrc_A !== 1'b1) begin
            failures++;
            $display("FAIL andi got=%b", dut_ctl());
        end
        drive(6'b001111, 6'b000000, 1'b0);
        checks++;
        if (bus.out_select !== 2'b01 || bus.reg_write !== 1'b1) begin
            failures++;
            $display("FAIL lui got=%b", dut_ctl());
        end
        drive(6'b100011, 6'b000000, 1'b0);
        checks++;
        if (bus.reg_write !== 1'b1 || bus.se_ze !== 1'b1 || bus.ALU_Func !== 4'b0100 ||
            bus.mem_write !== 1'b0) begin
            failures++;
            $display("FAIL lw got=%b", dut_ctl());
        end
        drive(6'b101011, 6'b000000, 1'b0);
        checks++;
        if (bus.mem_write !== 1'b1 || bus.reg_write !== 1'b0) begin
            failures++;
            $display("FAIL sw got=%b", dut_ctl());
        end
    endtask

    task automatic test_illegal();
        drive(6'b111111, 6'b100000, 1'b1);
        checks++;
        if (dut_ctl() !== bubble()) begin
            failures++;
            $display("FAIL illegal_op got=%b exp=%b", dut_ctl(), bubble());
        end
        drive(6'b000000, 6'b111111, 1'b0);
        checks++;
        if (dut_ctl() !== bubble()) begin
            failures++;
            $display("FAIL illegal_funct got=%b exp=%b", dut_ctl(), bubble());
        end
        drive(6'b000000, 6'b000000, 1'b0);
        checks++;
        if (dut_ctl() !== bubble()) begin
            failures++;
            $display("FAIL nop got=%b exp=%b", dut_ctl(), bubble());
        end
    endtask

    // Back-to-back random instructions every cycle with occasional reset
    // pulses; checks zero-latency decode and mid-run reset behaviour.
    task automatic test_back_to_back();
        logic [5:0] legal_ops [15] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                                      6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
        logic [5:0] legal_fn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                     6'h0c, 6'h2a, 6'h2b, 6'h10, 6'h12, 6'h18, 6'h19};
        logic [5:0] op;
        logic [5:0] fn;
        bit         eq;
        ctl_t       exp;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_ops[$urandom_range(0, 14)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_fn[$urandom_range(0, 13)];
            eq = 1'($urandom_range(0, 1));
            @(negedge clk);
            rst_n = ($urandom_range(0, 19) != 0);
            bus.op_code            = op;
            bus.control_unit_funct = fn;
            bus.eq_ne              = eq;
            #2;
            exp = model(op, fn, eq, m_in_rst);
            checks++;
            if (dut_ctl() !== exp) begin
                failures++;
                $display("FAIL rand_%0d op=%b fn=%b eq=%b rst=%b got=%b exp=%b",
                         i, op, fn, eq, m_in_rst, dut_ctl(), exp);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n                  = 1'b1;
        bus.op_code            = 6'b001000;
        bus.control_unit_funct = 6'b000000;
        bus.eq_ne              = 1'b0;
        build_table();
        test_reset();
        test_rtype();
        test_mult();
        test_branch();
        test_imm_mem();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
